// File: rtl/adc_lane_align_ctrl.sv
// Word-alignment sequencer for the ADC data lanes: once the frame clock is aligned it bitslips
// each lane in turn until the training pattern is seen on MATCHES consecutive compares.
module adc_lane_align_ctrl #(
    parameter int          LANES       = 4,
    parameter logic [7:0]  PATTERN     = 8'hA5,
    parameter int          SETTLE      = 8,
    parameter int          MATCHES     = 4,
    parameter int          FCO_TIMEOUT = 1024,
    localparam int         CW          = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               CLKDIV,
    input  logic               rst,
    input  logic               start,
    input  logic               fco_aligned,
    input  logic [8*LANES-1:0] lane_data,
    output logic [LANES-1:0]   lane_bslip,
    output logic               test_pattern_en,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [LANES-1:0]   lane_ok,
    output logic [CW-1:0]      cur_lane
);

    // state    | meaning
    // IDLE     | waiting for start          WAIT_FCO | waiting for frame alignment (with timeout)
    // SETTLE   | letting the lane settle    CHECK    | comparing lane word to PATTERN
    // SLIP     | one bitslip pulse          NEXT     | advance lane or finish
    // DONE     | all lanes aligned          FAIL     | timeout or lane never matched
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int MW = (MATCHES > 1) ? $clog2(MATCHES) : 1;
    localparam int TW = (FCO_TIMEOUT > 1) ? $clog2(FCO_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_FCO, S_SETTLE, S_CHECK, S_SLIP, S_NEXT, S_DONE, S_FAIL
    } state_t;

    state_t           r_state,   w_state_nxt;
    logic [CW-1:0]    r_lane,    w_lane_nxt;
    logic [2:0]       r_slip,    w_slip_nxt;
    logic [SW-1:0]    r_settle,  w_settle_nxt;
    logic [MW-1:0]    r_match,   w_match_nxt;
    logic [TW-1:0]    r_tmo,     w_tmo_nxt;
    logic [LANES-1:0] r_lane_ok, w_lane_ok_nxt;
    logic             r_fail,    w_fail_nxt;
    logic [7:0]       w_lane_word;

    assign w_lane_word = lane_data[8*int'(r_lane) +: 8];

    always_ff @(posedge CLKDIV or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lane    <= '0;
            r_slip    <= '0;
            r_settle  <= '0;
            r_match   <= '0;
            r_tmo     <= '0;
            r_lane_ok <= '0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lane    <= w_lane_nxt;
            r_slip    <= w_slip_nxt;
            r_settle  <= w_settle_nxt;
            r_match   <= w_match_nxt;
            r_tmo     <= w_tmo_nxt;
            r_lane_ok <= w_lane_ok_nxt;
            r_fail    <= w_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lane_nxt    = r_lane;
        w_slip_nxt    = r_slip;
        w_settle_nxt  = r_settle;
        w_match_nxt   = r_match;
        w_tmo_nxt     = r_tmo;
        w_lane_ok_nxt = r_lane_ok;
        w_fail_nxt    = r_fail;

        case (r_state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    w_state_nxt   = S_WAIT_FCO;
                    w_lane_ok_nxt = '0;
                    w_fail_nxt    = 1'b0;
                    w_lane_nxt    = '0;
                    w_tmo_nxt     = '0;
                end
            end
            S_WAIT_FCO: begin
                if (fco_aligned) begin
                    w_state_nxt  = S_SETTLE;
                    w_settle_nxt = '0;
                    w_slip_nxt   = '0;
                    w_match_nxt  = '0;
                end else if (r_tmo == TW'(FCO_TIMEOUT - 1)) begin
                    w_state_nxt = S_FAIL;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            S_SETTLE, S_CHECK, S_SLIP, S_NEXT: begin
                // Losing frame alignment invalidates everything done so far.
                if (!fco_aligned) begin
                    w_state_nxt   = S_WAIT_FCO;
                    w_lane_ok_nxt = '0;
                    w_fail_nxt    = 1'b0;
                    w_lane_nxt    = '0;
                    w_tmo_nxt     = '0;
                end else if (r_state == S_SETTLE) begin
                    if (r_settle == SW'(SETTLE - 1)) begin
                        w_state_nxt = S_CHECK;
                        w_match_nxt = '0;
                    end else begin
                        w_settle_nxt = r_settle + SW'(1);
                    end
                end else if (r_state == S_CHECK) begin
                    if (w_lane_word == PATTERN) begin
                        if (r_match == MW'(MATCHES - 1)) begin
                            w_lane_ok_nxt[r_lane] = 1'b1;
                            w_state_nxt           = S_NEXT;
                        end else begin
                            w_match_nxt = r_match + MW'(1);
                        end
                    end else if (r_slip == 3'd7) begin
                        w_fail_nxt  = 1'b1;
                        w_state_nxt = S_NEXT;
                    end else begin
                        w_match_nxt = '0;
                        w_state_nxt = S_SLIP;
                    end
                end else if (r_state == S_SLIP) begin
                    w_slip_nxt   = r_slip + 3'd1;
                    w_settle_nxt = '0;
                    w_state_nxt  = S_SETTLE;
                end else begin
                    if (r_lane == CW'(LANES - 1)) begin
                        w_state_nxt = r_fail ? S_FAIL : S_DONE;
                    end else begin
                        w_lane_nxt   = r_lane + CW'(1);
                        w_slip_nxt   = '0;
                        w_settle_nxt = '0;
                        w_match_nxt  = '0;
                        w_state_nxt  = S_SETTLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy            = (r_state == S_WAIT_FCO) || (r_state == S_SETTLE) ||
                             (r_state == S_CHECK)    || (r_state == S_SLIP)   ||
                             (r_state == S_NEXT);
    assign test_pattern_en = busy;
    assign done            = (r_state == S_DONE);
    assign error           = (r_state == S_FAIL);
    assign lane_bslip      = (r_state == S_SLIP) ? (LANES'(1) << r_lane) : '0;
    assign lane_ok         = r_lane_ok;
    assign cur_lane        = r_lane;

endmodule

// File: doc/adc_lane_align_ctrl.md
# adc_lane_align_ctrl

Sequencer that word-aligns the ADC data lanes after frame-clock (FCO) alignment has completed. It steps through the lanes one at a time. For each lane it issues ISERDES bitslip pulses until that lane's deserialized word matches a known ADC training pattern for several consecutive cycles. It then reports per-lane and overall alignment status to the capture logic and the ADC configuration sequencer.

## Interface
Parameters:
- LANES, 4, number of ADC data lanes (≥1)
- PATTERN, 8'hA5, training word each lane must present once aligned
- SETTLE, 8, CLKDIV cycles waited after any slip or lane change before comparing (≥1)
- MATCHES, 4, consecutive matching cycles required to declare a lane aligned (≥1)
- FCO_TIMEOUT, 1024, CLKDIV cycles allowed in WAIT_FCO before failing

Ports:
- CLKDIV  in  1  deserializer divided clock; sole clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin or re-run alignment
- fco_aligned  in  1  frame alignment complete (level)
- lane_data  in  8*LANES  deserialized words; lane i on bits [8i+7:8i]
- lane_bslip  out  LANES  one-cycle bitslip pulse to lane i's ISERDES
- test_pattern_en  out  1  request for the ADC to output PATTERN
- busy  out  1  alignment in progress
- done  out  1  all lanes aligned (level)
- error  out  1  alignment failed (level)
- lane_ok  out  LANES  per-lane aligned flags
- cur_lane  out  max(1,$clog2(LANES))  lane currently being processed

## Operation
- Counters: lane index, slip_cnt (3 bits, 0..7), settle_cnt, match_cnt, timeout counter. All counters and state are registered.
- Outputs are Moore: decoded from state, lane index and the lane_ok/fail registers only.
- Reset: state IDLE. lane_bslip=0, test_pattern_en=0, busy=0, done=0, error=0, lane_ok=0, cur_lane=0.
- IDLE: on start, go to WAIT_FCO. Clear lane_ok and the fail flag; set lane=0 and the timeout counter to 0.
- WAIT_FCO: if fco_aligned=1, go to SETTLE with settle/slip/match counts at 0. Otherwise increment the timeout counter. If it reaches FCO_TIMEOUT-1 without fco_aligned, go to FAIL.
- SETTLE: increment settle_cnt. When settle_cnt==SETTLE-1, go to CHECK with match_cnt=0.
- CHECK: compare the selected lane's word against PATTERN.
  - On a match with match_cnt==MATCHES-1, set lane_ok[lane] and go to NEXT. On any other match, increment match_cnt.
  - On a mismatch with slip_cnt==7, set the fail flag and go to NEXT; lane_ok[lane] stays 0. On any other mismatch, go to SLIP. A mismatch discards any partial match_cnt.
- SLIP: lane_bslip[lane]=1 for exactly this cycle; increment slip_cnt; go to SETTLE with settle_cnt=0.
- NEXT: if lane==LANES-1, go to DONE when the fail flag is clear, otherwise FAIL. Else increment lane, clear slip/settle/match counts and go to SETTLE.
- DONE: done=1. FAIL: error=1. In both states, start re-enters WAIT_FCO with the same clearing as from IDLE.
- test_pattern_en=1 and busy=1 in WAIT_FCO, SETTLE, CHECK, SLIP and NEXT; 0 elsewhere.
- While busy, start is ignored.
- fco_aligned=0 in SETTLE, CHECK, SLIP or NEXT: go to WAIT_FCO, clear lane_ok and the fail flag, and set lane=0. This has priority over all other transitions in those states.
- At most one bit of lane_bslip is ever high, and only in SLIP.
- Illegal state encodings recover to IDLE.
- rst asserted mid-operation: all outputs return to their reset values immediately, without waiting for a clock edge.

## Timing
- Edge E0 samples start in IDLE; busy and test_pattern_en rise after E0.
- With fco_aligned already high, SETTLE begins after E1.
- Per lane with no slips: SETTLE+MATCHES+1 cycles (13 at defaults).
- Each slip adds 1 mismatch CHECK cycle + 1 SLIP cycle + SETTLE cycles (10 at defaults).
- At defaults with all lanes pre-aligned, done rises after edge E53 and busy falls on the same edge.
- lane_bslip pulse to the first post-slip comparison: SETTLE+1 cycles.
- Worst-case lane failure: 7 slips and 8 bit positions tested.

## Test plan
- Defaults, fco_aligned=1, every lane constant 8'hA5, start pulse -> no lane_bslip pulses; done=1 after E53; lane_ok=4'b1111; error=0; test_pattern_en falls with busy.
- Bench rotates lane 2's word by one bit per received slip, starting 3 rotations off -> exactly 3 pulses on lane_bslip[2], each spaced 10 cycles apart; done after E83; lane_ok=4'b1111.
- Lane 1 never presents 8'hA5 -> 7 pulses on lane_bslip[1], then processing continues to lanes 2-3; final state FAIL with error=1, done=0, lane_ok=4'b1101.
- fco_aligned held 0 after start -> error rises after FCO_TIMEOUT cycles (1024) in WAIT_FCO; lane_ok=0; no slip pulses.
- fco_aligned dropped for one cycle while lane 2 is in CHECK -> return to WAIT_FCO, lane_ok cleared, cur_lane=0; after fco_aligned returns, full rerun ends in done=1.
- rst asserted during a SLIP cycle -> lane_bslip, busy and test_pattern_en go to 0 before the next edge; lane_ok=0; start is only accepted after rst is released.
